aurora_frame_assembler: RTL and testbench
=========================================

Name: aurora_frame_assembler

Overview:
Receives the 64-bit Aurora RX stream and rebuilds fixed-length data frames. Each frame starts with a word whose MSB is the frame-start marker. The block strips the marker bits, packs the payloads of one frame into a single wide output word, and presents it on a valid/ready port. It also tracks lock state and keeps saturating error counters. It sits between the Aurora core's user interface and the downstream ADC/SDM data FIFO, in the same clock domain as USER_CLK.

Parameters:
DATA_WIDTH, 64, input word width; bit DATA_WIDTH-1 is the frame-start marker.
FRAME_WORDS, 9, words per frame (minimum 2).
CNT_WIDTH, 16, width of each error/frame counter.
PW (localparam), DATA_WIDTH-1, payload bits per word.

Ports:
CLK  in  1  user clock, rising edge.
RESETN  in  1  asynchronous, active-low reset.
S_TDATA  in  DATA_WIDTH  Aurora RX data.
S_TVALID  in  1  word valid. No backpressure: every valid word is consumed.
DOUT  out  FRAME_WORDS*PW  assembled frame payload.
DOUT_VALID  out  1  frame available.
DOUT_READY  in  1  downstream accepts the frame when high together with DOUT_VALID.
LOCKED  out  1  high while in ASSEMBLE state.
CLEAR_CNT  in  1  synchronous clear of all counters.
FRAME_CNT  out  CNT_WIDTH  frames delivered to DOUT.
SHORT_ERR_CNT  out  CNT_WIDTH  frames cut short by an early marker.
SYNC_ERR_CNT  out  CNT_WIDTH  expected marker missing.
DROP_CNT  out  CNT_WIDTH  complete frames dropped because the output was still occupied.

Behaviour:
- Reset (RESETN low, asynchronous): state = HUNT, word index = 0, DOUT = 0, DOUT_VALID = 0, LOCKED = 0, all counters = 0.
- Reset asserted mid-frame discards the partial frame. The first frame after release requires a fresh marker.
- Packing: payload of word k (S_TDATA[PW-1:0]) lands in DOUT[k*PW +: PW]. Word 0 is the marker word.
- HUNT state:
  - Valid words without a marker are discarded silently.
  - A valid word with a marker is stored as word 0; index becomes 1; next state = ASSEMBLE.
- ASSEMBLE state, valid word, index in 1..FRAME_WORDS-1:
  - Marker = 0: store the word at the current index; index increments.
  - Marker = 1: SHORT_ERR_CNT increments, the partial frame is discarded, this word becomes word 0, and index becomes 1. State stays ASSEMBLE.
- Frame complete: the cycle the word at index FRAME_WORDS-1 is stored.
  - If the output register is free (DOUT_VALID = 0, or DOUT_VALID = 1 with DOUT_READY = 1 in the same cycle), the assembled frame loads into DOUT. DOUT_VALID is high the next cycle, so latency is 1 cycle from the last word to DOUT_VALID. FRAME_CNT increments.
  - Otherwise the frame is dropped, DROP_CNT increments, and DOUT is unchanged.
  - In both cases index becomes 0, waiting for the next marker.
- ASSEMBLE state, valid word, index 0:
  - Marker = 1: start a new frame.
  - Marker = 0: SYNC_ERR_CNT increments, the word is discarded, and next state = HUNT.
- Words with S_TVALID = 0 change nothing. Gaps are allowed anywhere, including inside a frame.
- Output handshake:
  - DOUT_VALID stays high and DOUT stays stable until DOUT_READY is sampled high.
  - DOUT_VALID clears the cycle after acceptance unless a new frame loads in that same cycle.
- Counters:
  - Each counter saturates at 2^CNT_WIDTH-1.
  - CLEAR_CNT has priority over an increment in the same cycle.
  - Counters do not affect data flow.
- LOCKED = (state == ASSEMBLE) and is registered.

Test Plan:
1. Continuous S_TVALID, frames of 9 words, marker on word 0, payloads 0x1..0x9 -> DOUT_VALID one cycle after word 9. DOUT[62:0] = 1 and DOUT[566:504] = 9. FRAME_CNT = 1. LOCKED high from the cycle after the first marker.
2. Stream starts at word index 4 of a frame (markerless words first), DOUT_READY = 1 -> the first 5 words are discarded in HUNT and the first output is the next complete frame. No counter besides FRAME_CNT increments.
3. Marker injected on word 5 of a frame -> SHORT_ERR_CNT = 1. The following frame assembles from that marker word and is output correctly.
4. Marker cleared on the first word of the second frame -> SYNC_ERR_CNT = 1, LOCKED drops, and re-lock occurs on the next marker.
5. DOUT_READY held low for 3 frames -> frame 1 is held stable, DROP_CNT = 2, FRAME_CNT = 1. Raising READY at the same cycle as a frame completes -> the new frame loads with no drop.
6. S_TVALID low every 32nd cycle, plus RESETN pulsed low mid-frame -> gaps cause no errors. After reset all outputs are 0 and the first frame output starts at the next marker. CLEAR_CNT zeroes counters even when an increment occurs in the same cycle.

Source files
------------

// File: rtl/aurora_frame_assembler.sv
// aurora_frame_assembler: rebuilds fixed-length marker-delimited frames from the Aurora RX stream
// and presents them on a valid/ready port with lock tracking and saturating error counters.
module aurora_frame_assembler #(
  parameter int DATA_WIDTH  = 64,
  parameter int FRAME_WORDS = 9,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_resetn,
  input  logic [DATA_WIDTH-1:0]                 i_s_tdata,
  input  logic                                  i_s_tvalid,
  output logic [FRAME_WORDS*(DATA_WIDTH-1)-1:0] o_dout,
  output logic                                  o_dout_valid,
  input  logic                                  i_dout_ready,
  output logic                                  o_locked,
  input  logic                                  i_clear_cnt,
  output logic [CNT_WIDTH-1:0]                  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]                  o_short_err_cnt,
  output logic [CNT_WIDTH-1:0]                  o_sync_err_cnt,
  output logic [CNT_WIDTH-1:0]                  o_drop_cnt
);
  localparam int PW = DATA_WIDTH - 1;
  localparam int IW = $clog2(FRAME_WORDS + 1);
  typedef enum logic {HUNT, ASSEMBLE} state_t;
  state_t                     r_state, w_state_nx;
  logic [IW-1:0]              r_idx, w_idx_nx, w_wpos;
  logic [FRAME_WORDS*PW-1:0]  r_buf, r_dout, w_frame;
  logic                       r_dout_valid;
  logic [CNT_WIDTH-1:0]       r_frame_cnt, r_short_cnt, r_sync_cnt, r_drop_cnt;
  logic                       w_mark, w_wr, w_short, w_sync, w_done, w_load, w_drop;
  function automatic logic [CNT_WIDTH-1:0] f_cnt(logic [CNT_WIDTH-1:0] c, logic inc, logic clr);
    return clr ? '0 : c + CNT_WIDTH'(inc && !(&c));
  endfunction
  assign w_mark  = i_s_tdata[DATA_WIDTH-1];
  assign w_wpos  = w_mark ? '0 : r_idx;
  assign w_frame = {i_s_tdata[PW-1:0], r_buf[(FRAME_WORDS-1)*PW-1:0]};
  assign w_load  = w_done && (!r_dout_valid || i_dout_ready);
  assign w_drop  = w_done && !w_load;
  // A marker always restarts a frame at word 0; in ASSEMBLE with a partial frame it is a short error.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_wr       = 1'b0;
    w_short    = 1'b0;
    w_sync     = 1'b0;
    w_done     = 1'b0;
    if (i_s_tvalid) begin
      if (w_mark) begin
        w_wr       = 1'b1;
        w_idx_nx   = IW'(1);
        w_state_nx = ASSEMBLE;
        w_short    = (r_state == ASSEMBLE) && (r_idx != '0);
      end else if (r_state == ASSEMBLE && r_idx == '0) begin
        w_sync     = 1'b1;
        w_state_nx = HUNT;
      end else if (r_state == ASSEMBLE) begin
        w_wr     = 1'b1;
        w_done   = (r_idx == IW'(FRAME_WORDS - 1));
        w_idx_nx = w_done ? '0 : r_idx + IW'(1);
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= HUNT;
      r_idx        <= '0;
      r_buf        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_cnt  <= '0;
      r_short_cnt  <= '0;
      r_sync_cnt   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      for (int k = 0; k < FRAME_WORDS; k++)
        if (w_wr && w_wpos == IW'(k)) r_buf[k*PW +: PW] <= i_s_tdata[PW-1:0];
      if (w_load) r_dout <= w_frame;
      r_dout_valid <= w_load || (r_dout_valid && !i_dout_ready);
      r_frame_cnt  <= f_cnt(r_frame_cnt, w_load, i_clear_cnt);
      r_short_cnt  <= f_cnt(r_short_cnt, w_short, i_clear_cnt);
      r_sync_cnt   <= f_cnt(r_sync_cnt, w_sync, i_clear_cnt);
      r_drop_cnt   <= f_cnt(r_drop_cnt, w_drop, i_clear_cnt);
    end
  end
  assign o_dout          = r_dout;
  assign o_dout_valid    = r_dout_valid;
  assign o_locked        = (r_state == ASSEMBLE);
  assign o_frame_cnt     = r_frame_cnt;
  assign o_short_err_cnt = r_short_cnt;
  assign o_sync_err_cnt  = r_sync_cnt;
  assign o_drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_aurora_frame_assembler.sv
// tb_aurora_frame_assembler: directed checks of frame assembly, error handling, backpressure,
// reset and counter clear; a second narrow-counter instance exercises saturation.
module tb_aurora_frame_assembler;
  localparam int DW = 64, FW = 9, CW = 16, PW = DW - 1, OW = FW * PW;
  logic          clk = 1'b0, resetn = 1'b0, tvalid = 1'b0, ready = 1'b1, clear = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [OW-1:0] dout, s_dout;
  logic          dout_valid, locked, s_valid, s_locked;
  logic [CW-1:0] frame_cnt, short_cnt, sync_cnt, drop_cnt;
  logic [1:0]    s_frame, s_short, s_sync, s_drop;
  int total = 0, bad = 0;
  aurora_frame_assembler #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .CNT_WIDTH(CW)) u_dut (
    .i_clk(clk), .i_resetn(resetn), .i_s_tdata(tdata), .i_s_tvalid(tvalid),
    .o_dout(dout), .o_dout_valid(dout_valid), .i_dout_ready(ready), .o_locked(locked),
    .i_clear_cnt(clear), .o_frame_cnt(frame_cnt), .o_short_err_cnt(short_cnt),
    .o_sync_err_cnt(sync_cnt), .o_drop_cnt(drop_cnt));
  aurora_frame_assembler #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .CNT_WIDTH(2)) u_sat (
    .i_clk(clk), .i_resetn(resetn), .i_s_tdata(tdata), .i_s_tvalid(tvalid),
    .o_dout(s_dout), .o_dout_valid(s_valid), .i_dout_ready(ready), .o_locked(s_locked),
    .i_clear_cnt(clear), .o_frame_cnt(s_frame), .o_short_err_cnt(s_short),
    .o_sync_err_cnt(s_sync), .o_drop_cnt(s_drop));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(logic [DW-1:0] d, logic v);
    tdata = d;
    tvalid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(logic [62:0] base, int n);
    for (int k = 0; k < n; k++) step({k == 0, 63'(base + 63'(k))}, 1'b1);
  endtask
  function automatic logic [62:0] wd(int k);
    return dout[k*PW +: PW];
  endfunction
  initial begin
    logic [OW-1:0] exp_frame;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_dout", 64'(dout == '0), 64'd1);
    chk("rst_cnts", 64'({frame_cnt, short_cnt, sync_cnt, drop_cnt}), 64'd0);
    resetn = 1'b1;
    // Basic frame with payloads 1..9
    step({1'b1, 63'h1}, 1'b1);
    chk("t1_locked", 64'(locked), 64'd1);
    for (int k = 1; k < FW; k++) begin
      chk("t1_not_valid", 64'(dout_valid), 64'd0);
      step({1'b0, 63'(k + 1)}, 1'b1);
    end
    for (int k = 0; k < FW; k++) exp_frame[k*PW +: PW] = 63'(k + 1);
    chk("t1_valid", 64'(dout_valid), 64'd1);
    chk("t1_dout_full", 64'(dout == exp_frame), 64'd1);
    chk("t1_w0", 64'(wd(0)), 64'h1);
    chk("t1_w8", 64'(dout[566:504]), 64'h9);
    chk("t1_fcnt", 64'(frame_cnt), 64'd1);
    step('0, 1'b0);
    chk("t1_accepted", 64'(dout_valid), 64'd0);
    // Join mid-frame: markerless words discarded while hunting
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) step({1'b0, 63'(4 + k)}, 1'b1);
    chk("t2_hunt_locked", 64'(locked), 64'd0);
    frame(63'h11, FW);
    chk("t2_valid", 64'(dout_valid), 64'd1);
    chk("t2_w0", 64'(wd(0)), 64'h11);
    chk("t2_w8", 64'(wd(8)), 64'h19);
    chk("t2_cnts", 64'({frame_cnt, short_cnt, sync_cnt, drop_cnt}), 64'h0001_0000_0000_0000);
    // Early marker cuts a frame short
    frame(63'h21, 5);
    frame(63'h31, FW);
    chk("t3_short", 64'(short_cnt), 64'd1);
    chk("t3_w0", 64'(wd(0)), 64'h31);
    chk("t3_w5", 64'(wd(5)), 64'h36);
    chk("t3_fcnt", 64'(frame_cnt), 64'd2);
    // Missing marker drops lock; relock on next marker
    step({1'b0, 63'h40}, 1'b1);
    chk("t4_sync", 64'(sync_cnt), 64'd1);
    chk("t4_unlocked", 64'(locked), 64'd0);
    for (int k = 1; k < FW; k++) step({1'b0, 63'(8'h40 + k)}, 1'b1);
    chk("t4_still_hunt", 64'(locked), 64'd0);
    frame(63'h41, FW);
    chk("t4_relocked", 64'(locked), 64'd1);
    chk("t4_w0", 64'(wd(0)), 64'h41);
    chk("t4_fcnt", 64'(frame_cnt), 64'd3);
    chk("t4_sync_hold", 64'(sync_cnt), 64'd1);
    step('0, 1'b0);
    // Backpressure: held output, drops, then simultaneous accept/load
    ready = 1'b0;
    frame(63'h51, FW);
    chk("t5_a_valid", 64'(dout_valid), 64'd1);
    frame(63'h61, FW);
    frame(63'h71, FW);
    chk("t5_held_valid", 64'(dout_valid), 64'd1);
    chk("t5_held_w0", 64'(wd(0)), 64'h51);
    chk("t5_held_w8", 64'(wd(8)), 64'h59);
    chk("t5_drop", 64'(drop_cnt), 64'd2);
    chk("t5_fcnt", 64'(frame_cnt), 64'd4);
    frame(63'h81, FW - 1);
    ready = 1'b1;
    step({1'b0, 63'h89}, 1'b1);
    chk("t5_d_valid", 64'(dout_valid), 64'd1);
    chk("t5_d_w0", 64'(wd(0)), 64'h81);
    chk("t5_d_w8", 64'(wd(8)), 64'h89);
    chk("t5_d_drop", 64'(drop_cnt), 64'd2);
    chk("t5_d_fcnt", 64'(frame_cnt), 64'd5);
    chk("sat_fcnt", 64'(s_frame), 64'd3);
    chk("sat_drop", 64'(s_drop), 64'd2);
    step('0, 1'b0);
    chk("t5_d_accepted", 64'(dout_valid), 64'd0);
    // Gap inside a frame carrying a marker that must be ignored
    frame(63'h91, 4);
    step({1'b1, 63'h5A}, 1'b0);
    for (int k = 4; k < FW; k++) step({1'b0, 63'(8'h91 + k)}, 1'b1);
    chk("t6_gap_fcnt", 64'(frame_cnt), 64'd6);
    chk("t6_gap_errs", 64'({short_cnt, sync_cnt, drop_cnt}), 64'h0001_0001_0002);
    chk("t6_gap_w4", 64'(wd(4)), 64'h95);
    chk("t6_gap_w8", 64'(wd(8)), 64'h99);
    chk("sat_fcnt_hold", 64'(s_frame), 64'd3);
    step('0, 1'b0);
    // Asynchronous reset mid-frame
    frame(63'hA1, 4);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_locked", 64'(locked), 64'd0);
    chk("t6_rst_valid", 64'(dout_valid), 64'd0);
    chk("t6_rst_dout", 64'(dout == '0), 64'd1);
    chk("t6_rst_cnts", 64'({frame_cnt, short_cnt, sync_cnt, drop_cnt}), 64'd0);
    @(posedge clk);
    #2;
    resetn = 1'b1;
    for (int k = 4; k < FW; k++) step({1'b0, 63'(8'hA1 + k)}, 1'b1);
    chk("t6_post_rst_hunt", 64'(locked), 64'd0);
    chk("t6_post_rst_novalid", 64'(dout_valid), 64'd0);
    frame(63'hB1, FW);
    chk("t6_post_valid", 64'(dout_valid), 64'd1);
    chk("t6_post_w0", 64'(wd(0)), 64'hB1);
    chk("t6_post_cnts", 64'({frame_cnt, short_cnt, sync_cnt, drop_cnt}), 64'h0001_0000_0000_0000);
    step('0, 1'b0);
    // Clear wins over a same-cycle increment
    frame(63'hC1, FW - 1);
    clear = 1'b1;
    step({1'b0, 63'hC9}, 1'b1);
    clear = 1'b0;
    chk("t6_clr_fcnt", 64'(frame_cnt), 64'd0);
    chk("t6_clr_valid", 64'(dout_valid), 64'd1);
    chk("t6_clr_w8", 64'(wd(8)), 64'hC9);
    step('0, 1'b0);
    frame(63'hD1, FW);
    chk("t6_after_clr_fcnt", 64'(frame_cnt), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
